// File: rtl/banco_pulsos_pkg.sv
// Shared constants and types for the banco_pulsos button/switch front end.
// Mode codes, button indices and the per-button FSM state encoding.
package banco_pulsos_pkg;

  localparam logic [1:0] MODO_NORMAL = 2'd0;
  localparam logic [1:0] MODO_HORA   = 2'd1;
  localparam logic [1:0] MODO_FECHA  = 2'd2;
  localparam logic [1:0] MODO_TIMER  = 2'd3;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
  localparam int NUM_BTN    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DELAY,
    ST_REPEAT
  } btn_st_e;

  // Lowest switch index wins when several are set.
  function automatic logic [1:0] decode_modo(input logic [2:0] sw);
    logic [1:0] m;
    m = MODO_NORMAL;
    if (sw[0])      m = MODO_HORA;
    else if (sw[1]) m = MODO_FECHA;
    else if (sw[2]) m = MODO_TIMER;
    return m;
  endfunction

endpackage

// File: rtl/banco_pulsos_btn_repeat_fsm.sv
// One button: press pulse on the first sampled high level, then
// optional hold-to-repeat pulses after an initial delay.
module btn_repeat_fsm
  import banco_pulsos_pkg::*;
#(
  parameter bit REPEAT_EN    = 1'b1,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic db_i,
  input  logic suppress_i,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  btn_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (db_i) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT_EN ? ST_DELAY : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!db_i) state_d = ST_IDLE;
      end
      ST_DELAY: begin
        if (!db_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (!db_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RATE_LAST) begin
          fire  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Suppression only gates the strobe; timing keeps running.
    pulse_d = fire & ~suppress_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/banco_pulsos.sv
// Turns debounced buttons/switches into command strobes, a mode code
// and a 12/24 h format flag for the clock/date/timer FSMs.
module banco_pulsos
  import banco_pulsos_pkg::*;
#(
  parameter int         REPEAT_DELAY = 50_000_000,
  parameter int         REPEAT_RATE  = 10_000_000,
  parameter logic [4:0] REPEAT_MASK  = 5'b00011,
  parameter int         CNT_W        = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_db,
  input  logic [4:0] btn_db,
  output logic [4:0] btn_pulse,
  output logic [1:0] modo,
  output logic       modo_cambio,
  output logic       formato
);

  logic       conflict;
  logic [1:0] modo_q, modo_d;
  logic       modo_cambio_q, modo_cambio_d;
  logic       formato_q, formato_d;
  logic       primed_q, primed_d;

  assign conflict = btn_db[BTN_UP] & btn_db[BTN_DOWN];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_repeat_fsm #(
      .REPEAT_EN   (REPEAT_MASK[i]),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (reset),
      .db_i      (btn_db[i]),
      .suppress_i((i <= BTN_DOWN) ? conflict : 1'b0),
      .pulse_o   (btn_pulse[i])
    );
  end

  // No strobe on the first edge: power-up switch positions are not a change.
  always_comb begin
    modo_d        = decode_modo(sw_db[2:0]);
    modo_cambio_d = primed_q && (modo_d != modo_q);
    formato_d     = sw_db[3];
    primed_d      = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      modo_q        <= MODO_NORMAL;
      modo_cambio_q <= 1'b0;
      formato_q     <= 1'b0;
      primed_q      <= 1'b0;
    end else begin
      modo_q        <= modo_d;
      modo_cambio_q <= modo_cambio_d;
      formato_q     <= formato_d;
      primed_q      <= primed_d;
    end
  end

  assign modo        = modo_q;
  assign modo_cambio = modo_cambio_q;
  assign formato     = formato_q;

endmodule

// File: doc/banco_pulsos.md
Name: banco_pulsos

Overview:
- Consumer end of the debounced button/switch interface: takes clean levels from the debounce bank and turns them into single-cycle command strobes for the clock/date/timer FSMs.
- Buttons produce one-shot press pulses; UP/DOWN also produce hold-to-repeat pulses.
- Switches are decoded into a registered mode code plus a mode-change strobe.

Parameters:
- REPEAT_DELAY, 50_000_000, clk cycles from the first press pulse to the first repeat pulse (500 ms at 100 MHz).
- REPEAT_RATE, 10_000_000, clk cycles between consecutive repeat pulses (100 ms).
- REPEAT_MASK, 5'b00011, per-button repeat enable; bit0 = UP, bit1 = DOWN.
- CNT_W, 26, counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sw_db  in  4  debounced switches: [0] set hora, [1] set fecha, [2] set timer, [3] 12/24 h format
- btn_db  in  5  debounced buttons: [0] UP, [1] DOWN, [2] LEFT, [3] RIGHT, [4] CENTER
- btn_pulse  out  5  one-cycle command strobe per button
- modo  out  2  0 normal, 1 hora, 2 fecha, 3 timer
- modo_cambio  out  1  one-cycle strobe when modo changes
- formato  out  1  registered copy of sw_db[3]

Behaviour:
- Reset (reset=0, asynchronous): btn_pulse=0, modo=0, modo_cambio=0, formato=0, all FSMs IDLE, all counters 0, primed=0.
- All outputs are registered. A press pulse appears in the cycle after the first cycle in which btn_db[i]=1 is sampled, i.e. 1-cycle latency.
- Per-button FSM with states IDLE, HOLD, DELAY, REPEAT:
  - IDLE, db=1: pulse, counter←0. Go to DELAY if REPEAT_MASK[i], else HOLD.
  - HOLD: no pulses. db=0 → IDLE.
  - DELAY: counter increments. counter==REPEAT_DELAY-1 → pulse, counter←0, go to REPEAT.
  - REPEAT: counter increments. counter==REPEAT_RATE-1 → pulse, counter←0.
  - In any non-IDLE state, db=0 → IDLE and counter←0 on the same edge. No pulse on release.
- UP/DOWN conflict: while btn_db[0] and btn_db[1] are both 1, btn_pulse[1:0] is forced to 0. The FSMs keep running. When one button is released, the other continues its current timing; it does not restart.
- Any other combination of buttons pulses independently. Multiple bits of btn_pulse may be high in the same cycle.
- Button held through reset release: the FSM starts in IDLE and emits one press pulse 1 cycle after reset deasserts. This is intended.
- Mode decode priority: sw_db[0] > sw_db[1] > sw_db[2]; none set → 0. modo is registered.
- modo_cambio=1 for exactly one cycle when the new modo differs from the registered modo.
- primed is cleared at reset and set on the first clock edge after reset. modo_cambio is suppressed on that first edge, so switch positions at power-up do not generate a strobe.
- formato follows sw_db[3] with 1-cycle latency and has no strobe.
- Counters are free of wrap-around: they are always cleared on leaving DELAY/REPEAT and never exceed the parameter minus 1.
- REPEAT_DELAY and REPEAT_RATE must be ≥ 2; behaviour for smaller values is undefined.

Decomposition:
- Shared package banco_pulsos_pkg:
  - Mode constants MODO_NORMAL=0, MODO_HORA=1, MODO_FECHA=2, MODO_TIMER=3
  - Button index constants BTN_UP..BTN_CENTER
  - FSM state encoding IDLE/HOLD/DELAY/REPEAT
- One natural sub-module, btn_repeat_fsm (parameters REPEAT_EN, REPEAT_DELAY, REPEAT_RATE, CNT_W), instantiated five times.
- The top level contains the conflict mask, mode decoder and format register.

Test Plan (REPEAT_DELAY=10, REPEAT_RATE=4):
- Reset asserted mid-repeat with UP held → all outputs 0 immediately, without waiting for clk. After release: one pulse at cycle 1, then repeats resume from a fresh delay.
- UP rises at t=0 and is held 25 cycles → btn_pulse[0] high at t=1, 11, 15, 19, 23 only. Release at t=25 → no further pulses.
- CENTER held 30 cycles → exactly one btn_pulse[4] at t=1. Release and re-press → one new pulse.
- UP held, DOWN pressed at t=5 and released at t=13 → no bit of btn_pulse[1:0] during t=6..13. UP repeats resume on its own schedule, with the next pulse at t=15.
- sw_db=4'b0110 at reset release → modo=2, no modo_cambio. Then set sw_db[0] → modo=1 and modo_cambio high for 1 cycle. Toggle sw_db[3] → formato follows after 1 cycle, no strobe.
- UP pressed for a single cycle → exactly one pulse at t=1. FSM is back in IDLE at t=2.
